// File: rtl/ramb_pkg.sv
// Shared types and widths for the RAM B port arbiter.
// Imported by the interface, the picker and the top.
package ramb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        DONE
    } ramb_state_t;

    localparam int RAMB_AW = 16;
    localparam int RAMB_DW = 8;

endpackage

// File: rtl/ramb_port_arbiter_if.sv
// RAM B port bus between the arbiter (master) and the RAM pair (slave).
// One single-beat strobe, one ack per direction.
interface ramb_port_arbiter_if;
    import ramb_pkg::*;

    logic [RAMB_AW-1:0] ramb_addr;
    logic               ramb_wr;
    logic               ramb_rd;
    logic [RAMB_DW-1:0] ramb_dout;
    logic [RAMB_DW-1:0] ramb_din;
    logic               ramb_wr_ack;
    logic               ramb_rd_ack;

    modport master (
        output ramb_addr,
        output ramb_wr,
        output ramb_rd,
        output ramb_dout,
        input  ramb_din,
        input  ramb_wr_ack,
        input  ramb_rd_ack
    );

    modport slave (
        input  ramb_addr,
        input  ramb_wr,
        input  ramb_rd,
        input  ramb_dout,
        output ramb_din,
        output ramb_wr_ack,
        output ramb_rd_ack
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first pending index after rr_ptr,
// wrapping modulo NREQ; rr_ptr itself has the lowest priority.
module rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         pend,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    vld
);
    localparam int IW = $clog2(NREQ);

    int j;

    // Walk from the farthest offset to the nearest so the nearest wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        j   = 0;
        for (int i = NREQ; i >= 1; i--) begin
            j = (int'(rr_ptr) + i) % NREQ;
            if (pend[j]) begin
                idx = IW'(j);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramb_port_arbiter.sv
// Round-robin arbiter sharing the RAM B port between NREQ requesters,
// one single-beat transaction at a time, with an ack watchdog.
module ramb_port_arbiter
    import ramb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [NREQ-1:0]         req_rd_i,
    input  logic [NREQ-1:0]         req_wr_i,
    input  logic [NREQ*RAMB_AW-1:0] req_addr_i,
    input  logic [NREQ*RAMB_DW-1:0] req_data_i,
    output logic [NREQ-1:0]         req_ack_o,
    output logic [NREQ-1:0]         req_err_o,
    output logic [RAMB_DW-1:0]      rd_data_o,
    output logic                    busy_o,
    ramb_port_arbiter_if.master     ramb
);
    localparam int         IW     = $clog2(NREQ);
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    ramb_state_t        state_q;
    ramb_state_t        state_d;
    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      gnt_q;
    logic [IW-1:0]      pick_idx;
    logic               pick_vld;
    logic               op_wr_q;
    logic               err_q;
    logic [RAMB_AW-1:0] addr_q;
    logic [RAMB_DW-1:0] data_q;
    logic [RAMB_DW-1:0] rd_data_q;
    logic [7:0]         wdog_q;
    logic [7:0]         wdog_inc;
    logic               wdog_exp;
    logic               ack_hit;
    logic [NREQ-1:0]    pend;

    assign pend = req_rd_i | req_wr_i;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr_q),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

    // Only the ack matching the latched op counts; the other is ignored.
    assign ack_hit  = op_wr_q ? ramb.ramb_wr_ack : ramb.ramb_rd_ack;
    assign wdog_inc = (wdog_q == 8'hFF) ? 8'hFF : wdog_q + 8'd1;
    assign wdog_exp = wdog_inc >= TO_CNT;

    assign rd_data_o = rd_data_q;

    always_comb begin
        state_d        = state_q;
        busy_o         = (state_q != IDLE);
        ramb.ramb_addr = addr_q;
        ramb.ramb_dout = data_q;
        ramb.ramb_wr   = 1'b0;
        ramb.ramb_rd   = 1'b0;
        req_ack_o      = '0;
        req_err_o      = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) state_d = ISSUE;
            end
            ISSUE: begin
                ramb.ramb_wr = op_wr_q;
                ramb.ramb_rd = !op_wr_q;
                state_d      = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ack_hit || wdog_exp) state_d = DONE;
            end
            DONE: begin
                req_ack_o[gnt_q] = 1'b1;
                req_err_o[gnt_q] = err_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= IW'(NREQ - 1);
            gnt_q     <= '0;
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            wdog_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q    <= pick_idx;
                        rr_ptr_q <= pick_idx;
                        op_wr_q  <= req_wr_i[pick_idx];
                        addr_q   <= req_addr_i[pick_idx*RAMB_AW +: RAMB_AW];
                        data_q   <= req_data_i[pick_idx*RAMB_DW +: RAMB_DW];
                    end
                end
                ISSUE: begin
                    wdog_q <= '0;
                end
                WAIT_ACK: begin
                    wdog_q <= wdog_inc;
                    if (ack_hit) begin
                        if (!op_wr_q) rd_data_q <= ramb.ramb_din;
                    end else if (wdog_exp) begin
                        err_q <= 1'b1;
                        if (!op_wr_q) rd_data_q <= '0;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ramb_port_arbiter.sv
// Self-checking bench for ramb_port_arbiter: directed cases plus random
// traffic, checked every cycle against a transaction-timestamp model.
module tb_ramb_port_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 15;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [NREQ-1:0]      req_rd;
    logic [NREQ-1:0]      req_wr;
    logic [NREQ*16-1:0]   req_addr;
    logic [NREQ*8-1:0]    req_data;
    logic [NREQ-1:0]      req_ack;
    logic [NREQ-1:0]      req_err;
    logic [7:0]           rd_data;
    logic                 busy;

    ramb_port_arbiter_if ramb_bus ();

    ramb_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .req_rd_i   (req_rd),
        .req_wr_i   (req_wr),
        .req_addr_i (req_addr),
        .req_data_i (req_data),
        .req_ack_o  (req_ack),
        .req_err_o  (req_err),
        .rd_data_o  (rd_data),
        .busy_o     (busy),
        .ramb       (ramb_bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    bit         m_busy;
    int         m_k;
    bit         m_wr;
    logic [15:0] m_addr;
    logic [7:0] m_data;
    logic [7:0] m_rd;
    int         m_issue;
    int         m_done;
    bit         m_err;
    int         m_rr;

    function automatic void model_reset();
        m_busy = 0; m_k = 0; m_wr = 0; m_addr = '0; m_data = '0;
        m_rd = '0; m_issue = -1; m_done = -1; m_err = 0; m_rr = NREQ - 1;
    endfunction

    function automatic void check_outputs();
        logic [NREQ-1:0] e_ack;
        logic [NREQ-1:0] e_err;
        bit strobe;
        bit done;
        strobe = m_busy && (cyc == m_issue);
        done   = m_busy && (cyc == m_done);
        e_ack  = '0;
        e_err  = '0;
        if (done) begin
            e_ack[m_k] = 1'b1;
            e_err[m_k] = m_err;
        end
        chk("busy", busy, m_busy);
        chk("ramb_wr", ramb_bus.ramb_wr, strobe && m_wr);
        chk("ramb_rd", ramb_bus.ramb_rd, strobe && !m_wr);
        chk("ramb_addr", ramb_bus.ramb_addr, m_addr);
        chk("ramb_dout", ramb_bus.ramb_dout, m_data);
        chk("req_ack", req_ack, e_ack);
        chk("req_err", req_err, e_err);
        chk("rd_data", rd_data, m_rd);
    endfunction

    function automatic void model_update();
        logic [NREQ-1:0] pend;
        bit found;
        int j;
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (!m_busy) begin
            pend  = req_rd | req_wr;
            found = 0;
            for (int i = 1; i <= NREQ; i++) begin
                j = (m_rr + i) % NREQ;
                if (!found && pend[j]) begin
                    found = 1;
                    m_k   = j;
                end
            end
            if (found) begin
                m_busy  = 1;
                m_wr    = req_wr[m_k];
                m_addr  = req_addr[16*m_k +: 16];
                m_data  = req_data[8*m_k +: 8];
                m_issue = cyc + 1;
                m_done  = -1;
                m_err   = 0;
                m_rr    = m_k;
            end
        end else if (cyc == m_done) begin
            m_busy = 0;
        end else if (cyc > m_issue && m_done < 0) begin
            if (m_wr ? ramb_bus.ramb_wr_ack : ramb_bus.ramb_rd_ack) begin
                m_done = cyc + 1;
                if (!m_wr) m_rd = ramb_bus.ramb_din;
            end else if (cyc - m_issue >= TIMEOUT) begin
                m_done = cyc + 1;
                m_err  = 1;
                if (!m_wr) m_rd = 8'h00;
            end
        end
    endfunction

    // ---------------- RAM pair model ----------------
    logic [7:0]  mem [0:65535];
    bit          r_pend;
    bit          r_wr;
    int          r_ack_cyc;
    logic [15:0] r_addr;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          last_issue = 0;
    logic [15:0] last_wr_addr;
    logic [7:0]  last_wr_dout;
    bit          lose_all = 0;
    bit          fixed_lat = 1;
    bit          spur_en = 0;

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(19));
        if (r < 2) return 0;
        if (r == 2) return 14;
        if (r == 3) return 15;
        if (r == 4) return 16;
        return 1 + (r % 3);
    endfunction

    task automatic ram_step();
        int lat;
        bit hit;
        hit = 0;
        if (ramb_bus.ramb_wr === 1'b1) begin
            mem[ramb_bus.ramb_addr] = ramb_bus.ramb_dout;
            last_wr_addr = ramb_bus.ramb_addr;
            last_wr_dout = ramb_bus.ramb_dout;
            wr_cnt++;
            r_wr = 1;
            hit = 1;
        end else if (ramb_bus.ramb_rd === 1'b1) begin
            rd_cnt++;
            r_wr = 0;
            r_addr = ramb_bus.ramb_addr;
            hit = 1;
        end
        if (hit) begin
            last_issue = cyc;
            lat = fixed_lat ? 1 : pick_lat();
            r_pend = !lose_all && lat > 0;
            r_ack_cyc = cyc + lat;
        end
        ramb_bus.ramb_wr_ack = 1'b0;
        ramb_bus.ramb_rd_ack = 1'b0;
        ramb_bus.ramb_din = 8'($urandom);
        if (r_pend && cyc == r_ack_cyc) begin
            r_pend = 0;
            if (r_wr) ramb_bus.ramb_wr_ack = 1'b1;
            else begin
                ramb_bus.ramb_rd_ack = 1'b1;
                ramb_bus.ramb_din = mem[r_addr];
            end
        end else if (spur_en && $urandom_range(7) == 0) begin
            if (r_wr) ramb_bus.ramb_rd_ack = 1'b1;
            else ramb_bus.ramb_wr_ack = 1'b1;
        end
    endtask

    // ---------------- requester agents ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
        bit          pulse;
        int          gap;
    } txn_t;

    txn_t       a_q [NREQ][$];
    txn_t       a_cur [NREQ];
    bit         a_act [NREQ];
    int         a_treq [NREQ];
    int         a_tack [NREQ];
    int         a_lat [NREQ];
    bit         a_err [NREQ];
    logic [7:0] a_rd [NREQ];
    int         a_done [NREQ];
    int         a_idle [NREQ];
    int         ack_log [$];

    task automatic push(input int k, input bit rd, input bit wr,
                        input logic [15:0] addr, input logic [7:0] data,
                        input bit pulse, input int gap);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.data = data;
        t.pulse = pulse; t.gap = gap;
        a_q[k].push_back(t);
    endtask

    task automatic agents_step();
        bit on;
        for (int k = 0; k < NREQ; k++) begin
            if (a_act[k] && req_ack[k] === 1'b1) begin
                a_act[k]  = 0;
                a_tack[k] = cyc;
                a_lat[k]  = cyc - a_treq[k];
                a_err[k]  = req_err[k];
                a_rd[k]   = rd_data;
                a_done[k]++;
                a_idle[k] = 0;
            end
            if (!a_act[k] && a_q[k].size() > 0) begin
                if (a_idle[k] >= a_q[k][0].gap) begin
                    a_cur[k]  = a_q[k].pop_front();
                    a_act[k]  = 1;
                    a_treq[k] = cyc;
                end else a_idle[k]++;
            end
            on = a_act[k] && !(a_cur[k].pulse && cyc != a_treq[k]);
            req_rd[k] = on && a_cur[k].rd;
            req_wr[k] = on && a_cur[k].wr;
            req_addr[16*k +: 16] = a_act[k] ? a_cur[k].addr : 16'($urandom);
            req_data[8*k +: 8]   = a_act[k] ? a_cur[k].data : 8'($urandom);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_outputs();
        for (int k = 0; k < NREQ; k++)
            if (req_ack[k] === 1'b1) ack_log.push_back(k);
        ram_step();
        agents_step();
        model_update();
    endtask

    task automatic wait_done(input int k, input int target);
        int n;
        n = 0;
        while (a_done[k] < target && n < 500) begin
            tick();
            n++;
        end
        chk("wait_done", 32'(a_done[k] >= target), 32'd1);
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NREQ; k++)
            if (a_act[k] || a_q[k].size() > 0) return 0;
        return 1;
    endfunction

    int exp3 [6];
    int t0, t1, n_ack, c_wr, c_rd, n_tot, n_before, guard;

    initial begin
        exp3 = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int k = 0; k < NREQ; k++) begin
            a_act[k] = 0; a_done[k] = 0; a_idle[k] = 0;
            a_rd[k] = '0; a_err[k] = 0; a_lat[k] = 0; a_tack[k] = 0;
        end
        r_pend = 0; r_wr = 0; r_ack_cyc = 0; r_addr = '0;
        reset_n = 1'b0;
        req_rd = '0; req_wr = '0; req_addr = '0; req_data = '0;
        ramb_bus.ramb_din = '0;
        ramb_bus.ramb_wr_ack = 1'b0;
        ramb_bus.ramb_rd_ack = 1'b0;
        model_reset();

        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_ack", req_ack, 0);
        chk("reset_addr", ramb_bus.ramb_addr, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) tick();

        // single write, latency 3, lands in upper bank
        push(0, 0, 1, 16'h8123, 8'hA5, 0, 0);
        wait_done(0, 1);
        chk("t1_latency", a_lat[0], 3);
        chk("t1_wr_addr", last_wr_addr, 16'h8123);
        chk("t1_wr_dout", last_wr_dout, 8'hA5);
        chk("t1_mem", mem[16'h8123], 8'hA5);
        repeat (2) tick();

        // read-back on requester 1
        push(1, 1, 0, 16'h8123, 8'h00, 0, 0);
        wait_done(1, 1);
        chk("t2_rd_data", a_rd[1], 8'hA5);
        chk("t2_err", a_err[1], 0);
        repeat (2) tick();

        // contention: alternating grants
        ack_log.delete();
        t0 = a_done[0] + 3;
        t1 = a_done[1] + 3;
        for (int i = 0; i < 3; i++) begin
            push(0, 0, 1, 16'h8123, 8'hA5, 0, 0);
            push(1, 1, 0, 16'h8123, 8'h00, 0, 0);
        end
        wait_done(0, t0);
        wait_done(1, t1);
        repeat (2) tick();
        chk("t3_count", ack_log.size(), 6);
        for (int i = 0; i < 6 && i < ack_log.size(); i++)
            chk("t3_order", ack_log[i], exp3[i]);

        // lost ack -> watchdog completion with err
        lose_all = 1;
        push(1, 1, 0, 16'h1234, 8'h00, 0, 0);
        wait_done(1, a_done[1] + 1);
        chk("t4_to_cycles", a_tack[1] - last_issue, 16);
        chk("t4_err", a_err[1], 1);
        chk("t4_rd_data", a_rd[1], 8'h00);
        lose_all = 0;
        repeat (2) tick();
        push(0, 0, 1, 16'h2000, 8'h5A, 0, 0);
        wait_done(0, a_done[0] + 1);
        chk("t4_next_err", a_err[0], 0);
        chk("t4_next_lat", a_lat[0], 3);
        repeat (2) tick();

        // rd+wr together is one write
        c_wr = wr_cnt; c_rd = rd_cnt; n_ack = ack_log.size();
        push(0, 1, 1, 16'h0010, 8'h3C, 0, 0);
        wait_done(0, a_done[0] + 1);
        repeat (3) tick();
        chk("t5_wr_cnt", wr_cnt - c_wr, 1);
        chk("t5_rd_cnt", rd_cnt - c_rd, 0);
        chk("t5_mem", mem[16'h0010], 8'h3C);
        chk("t5_acks", ack_log.size() - n_ack, 1);

        // request dropped right after latching still completes
        push(1, 1, 0, 16'h0010, 8'h00, 1, 0);
        wait_done(1, a_done[1] + 1);
        chk("drop_rd_data", a_rd[1], 8'h3C);
        repeat (2) tick();

        // async reset in WAIT_ACK
        lose_all = 1;
        push(0, 1, 0, 16'h0010, 8'h00, 0, 0);
        repeat (3) tick();
        chk("t6_pre_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_rd", ramb_bus.ramb_rd, 0);
        chk("t6_addr", ramb_bus.ramb_addr, 0);
        chk("t6_ack", req_ack, 0);
        chk("t6_rd_data", rd_data, 0);
        model_reset();
        for (int k = 0; k < NREQ; k++) begin
            a_act[k] = 0;
            a_q[k].delete();
        end
        r_pend = 0;
        lose_all = 0;
        n_ack = ack_log.size();
        repeat (3) tick();
        chk("t6_no_ack", ack_log.size() - n_ack, 0);
        ack_log.delete();
        push(0, 1, 0, 16'h8123, 8'h00, 0, 0);
        push(1, 1, 0, 16'h0010, 8'h00, 0, 0);
        tick();
        @(posedge clk);
        #2 reset_n = 1'b1;
        wait_done(0, a_done[0] + 1);
        wait_done(1, a_done[1] + 1);
        chk("t6_first", ack_log.size() > 0 ? ack_log[0] : -1, 0);
        repeat (2) tick();

        // random traffic
        fixed_lat = 0;
        spur_en = 1;
        n_before = 0;
        for (int k = 0; k < NREQ; k++) n_before += a_done[k];
        for (int i = 0; i < 200; i++) begin
            int op;
            op = int'($urandom_range(3));
            push(int'($urandom_range(NREQ - 1)), op != 1, op == 1 || op == 2,
                 16'($urandom), 8'($urandom), 0, int'($urandom_range(3)));
        end
        guard = 0;
        while (!all_idle() && guard < 20000) begin
            tick();
            guard++;
        end
        repeat (20) tick();
        n_tot = 0;
        for (int k = 0; k < NREQ; k++) n_tot += a_done[k];
        chk("rand_done", n_tot - n_before, 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
